// File: rtl/sim_finish_ctrl.sv
// End-of-test sequencer for the Verilator top: decodes test-status writes and the
// legacy GPIO signature, runs a watchdog, drains a fixed window, then pulses finish_o.
module sim_finish_ctrl #(
  parameter logic [31:0] StatusAddr    = 32'h0010_0000,
  parameter int unsigned DrainCycles   = 7,
  parameter logic [31:0] TimeoutCycles = 32'd10_000_000,
  parameter logic [31:0] LegacySig     = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wr_valid_i,
  input  logic [31:0] addr_i,
  input  logic [15:0] data_i,
  input  logic [31:0] gpio_i,
  output logic        done_o,
  output logic        passed_o,
  output logic        timeout_o,
  output logic [15:0] status_o,
  output logic        finish_o,
  output logic [1:0]  state_o
);

  // state  | meaning
  // RUN    | test running, watching status writes, GPIO and watchdog
  // DRAIN  | outcome decided, letting trailing DPI traffic flush
  // FIN    | one-cycle finish request
  // HALT   | outcome held until reset
  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDrain = 2'd1,
    StFin   = 2'd2,
    StHalt  = 2'd3
  } state_e;

  localparam logic [15:0] CodePass    = 16'h900D;
  localparam logic [15:0] CodeFail    = 16'hBAAD;
  localparam logic [7:0]  DrainLast   = 8'(DrainCycles - 1);
  localparam logic [31:0] WdLast      = TimeoutCycles - 32'd1;
  localparam logic        WdEn        = (TimeoutCycles != 32'd0);

  state_e      state_q, state_d;
  logic        done_q, done_d;
  logic        passed_q, passed_d;
  logic        timeout_q, timeout_d;
  logic [15:0] status_q, status_d;
  logic        finish_q, finish_d;
  logic [7:0]  drain_q, drain_d;
  logic [31:0] wd_q, wd_d;

  logic status_wr;
  logic legacy_hit;
  logic wd_hit;
  logic ev;
  logic ev_pass;
  logic ev_timeout;

  assign status_wr  = wr_valid_i && (addr_i == StatusAddr);
  assign legacy_hit = (gpio_i == LegacySig);
  assign wd_hit     = WdEn && (wd_q == WdLast);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StRun;
      done_q    <= 1'b0;
      passed_q  <= 1'b0;
      timeout_q <= 1'b0;
      status_q  <= 16'h0000;
      finish_q  <= 1'b0;
      drain_q   <= 8'd0;
      wd_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      passed_q  <= passed_d;
      timeout_q <= timeout_d;
      status_q  <= status_d;
      finish_q  <= finish_d;
      drain_q   <= drain_d;
      wd_q      <= wd_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    done_d     = done_q;
    passed_d   = passed_q;
    timeout_d  = timeout_q;
    status_d   = status_q;
    finish_d   = 1'b0;
    drain_d    = drain_q;
    wd_d       = wd_q;
    ev         = 1'b0;
    ev_pass    = 1'b0;
    ev_timeout = 1'b0;

    unique case (state_q)
      StRun: begin
        if (status_wr) begin
          status_d = data_i;
          wd_d     = 32'd0;
        end else if (wd_q != 32'hFFFF_FFFF) begin
          wd_d = wd_q + 32'd1;
        end

        // Status write outranks legacy GPIO, which outranks the watchdog.
        if (status_wr && (data_i == CodeFail)) begin
          ev = 1'b1;
        end else if (status_wr && (data_i == CodePass)) begin
          ev      = 1'b1;
          ev_pass = 1'b1;
        end else if (legacy_hit) begin
          ev      = 1'b1;
          ev_pass = 1'b1;
        end else if (!status_wr && wd_hit) begin
          ev         = 1'b1;
          ev_timeout = 1'b1;
        end

        if (ev) begin
          done_d    = 1'b1;
          passed_d  = ev_pass;
          timeout_d = ev_timeout;
          drain_d   = 8'd0;
          state_d   = StDrain;
        end
      end
      StDrain: begin
        drain_d = drain_q + 8'd1;
        if (drain_q == DrainLast) begin
          state_d  = StFin;
          finish_d = 1'b1;
        end
      end
      StFin: begin
        state_d = StHalt;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StHalt;
      end
    endcase
  end

  assign done_o    = done_q;
  assign passed_o  = passed_q;
  assign timeout_o = timeout_q;
  assign status_o  = status_q;
  assign finish_o  = finish_q;
  assign state_o   = state_q;

endmodule
